// File: rtl/booth_iter_mul_if.sv
// booth_iter_mul_if: valid/ready request and response bundle for booth_iter_mul
//   master: in_valid, src_a, src_b, sign, cancel, out_ready -> ; <- in_ready, out_valid, result_hi, result_lo
//   slave : mirror of master
interface booth_iter_mul_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, sign, cancel, out_valid, out_ready;
  logic [WIDTH-1:0] src_a, src_b, result_hi, result_lo;
  modport master(output in_valid, src_a, src_b, sign, cancel, out_ready,
                 input in_ready, out_valid, result_hi, result_lo);
  modport slave(input in_valid, src_a, src_b, sign, cancel, out_ready,
                output in_ready, out_valid, result_hi, result_lo);
endinterface

// File: rtl/booth_iter_mul.sv
// booth_iter_mul: iterative radix-4 Booth multiplier, one digit per cycle, 2*WIDTH-bit product
//   clk, resetn (sync, active-low); bus: booth_iter_mul_if.slave request/response handshake
//   optional macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier digits are all zero
module booth_iter_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic resetn,
  booth_iter_mul_if.slave bus
);
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int BW = WIDTH + 3;
  localparam int PW = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH+1:0] a;
  logic [BW-1:0] b;
  logic [PW-1:0] acc, acc_nx, m, res;
  logic [CNT_W:0] sh;
  logic [2:0] trip;
  logic neg, last;
  always_comb begin
    sh = {cnt, 1'b0};
    trip = b[sh +: 3];
    neg = trip[2] & ~&trip;
    m = (trip == 3'b011 || trip == 3'b100) ? {{(WIDTH-3){a[WIDTH+1]}}, a, 1'b0} :
        (trip == 3'b000 || trip == 3'b111) ? '0 : {{(WIDTH-2){a[WIDTH+1]}}, a};
    // negative digits: inverted partial product plus a +1 injected at bit 2i
    acc_nx = acc + ((neg ? ~m : m) << sh) + (PW'(neg) << sh);
    last = cnt == CNT_W'(NDIG - 1);
`ifdef BOOTH_EARLY_TERM_EN
    // b holds B[-1] at bit 0, so unprocessed bits B[2i+1] upward start at b[2i+2]
    last = last | ((b >> (sh + 2'd2)) == ({BW{b[BW-1]}} >> (sh + 2'd2)));
`endif
    nxt = bus.cancel ? IDLE :
          (state == IDLE && bus.in_valid) ? BUSY :
          (state == BUSY && last) ? DONE :
          (state == DONE && bus.out_ready) ? IDLE : state;
    bus.in_ready = resetn && state == IDLE;
    bus.out_valid = state == DONE;
    bus.result_hi = res[PW-1:WIDTH];
    bus.result_lo = res[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      a <= '0;
      b <= '0;
      acc <= '0;
      res <= '0;
    end else begin
      state <= nxt;
      if (bus.cancel) cnt <= '0;
      else if (state == IDLE && bus.in_valid) begin
        a <= bus.sign ? {{2{bus.src_a[WIDTH-1]}}, bus.src_a} : {2'b00, bus.src_a};
        b <= bus.sign ? {{2{bus.src_b[WIDTH-1]}}, bus.src_b, 1'b0} : {2'b00, bus.src_b, 1'b0};
        acc <= '0;
        cnt <= '0;
      end else if (state == BUSY) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        if (last) res <= acc_nx;
      end
    end
  end
endmodule

// File: tb/tb_booth_iter_mul.sv
// tb_booth_iter_mul: randomized self-checking bench against a plain-arithmetic product and latency model
module tb_booth_iter_mul;
  logic clk, resetn;
  int checks = 0, errors = 0;
  logic expv = 0;
  logic [63:0] expp = '0;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  booth_iter_mul_if #(.WIDTH(32)) bus();
  booth_iter_mul #(.WIDTH(32), .CNT_W(5)) dut(.clk(clk), .resetn(resetn), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, required completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction
  // digits needed: the first k for which every multiplier bit from B[2k-1] upward equals the extension bit
  function automatic int ref_lat(input logic [31:0] y, input logic s);
    logic [34:0] be, ex;
    be = {s & y[31], s & y[31], y, 1'b0};
    ex = {35{be[34]}};
    for (int k = 1; k < 17; k++) if (EARLY && (be >> (2 * k)) == (ex >> (2 * k))) return k;
    return 17;
  endfunction
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (!expv) chk("spurious_out_valid", 64'd1, 64'd0);
      else chk("result", {bus.result_hi, bus.result_lo}, expp);
    end
  end
  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic s, input int hold);
    int n;
    @(negedge clk);
    chk("in_ready_before", {63'b0, bus.in_ready}, 64'd1);
    expp = ref_mul(x, y, s);
    expv = 1;
    bus.in_valid = 1;
    bus.src_a = x;
    bus.src_b = y;
    bus.sign = s;
    bus.out_ready = hold == 0;
    @(negedge clk);
    bus.in_valid = 0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(ref_lat(y, s)));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {63'b0, bus.out_valid}, 64'd1);
      chk("hold_in_ready", {63'b0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk("post_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("post_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("post_result_kept", {bus.result_hi, bus.result_lo}, expp);
    expv = 0;
  endtask
  initial begin
    logic [31:0] ra, rb;
    resetn = 0;
    bus.in_valid = 0;
    bus.src_a = 0;
    bus.src_b = 0;
    bus.sign = 0;
    bus.cancel = 0;
    bus.out_ready = 1;
    @(negedge clk);
    chk("reset_in_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("reset_result", {bus.result_hi, bus.result_lo}, 64'd0);
    resetn = 1;
    #1 chk("after_reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("model_3x5", ref_mul(32'd3, 32'd5, 0), 64'h0000_0000_0000_000F);
    chk("model_ffu", ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0), 64'hFFFFFFFE_00000001);
    chk("model_ffs", ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1), 64'h00000000_00000001);
    chk("model_min", ref_mul(32'h80000000, 32'h80000000, 1), 64'h40000000_00000000);
    chk("model_m3x7", ref_mul(32'hFFFFFFFD, 32'd7, 1), 64'hFFFFFFFF_FFFFFFEB);
    chk("model_2xm4", ref_mul(32'd2, 32'hFFFFFFFC, 1), 64'hFFFFFFFF_FFFFFFF8);
    chk("model_lat_0", 64'(ref_lat(32'd0, 0)), EARLY ? 64'd1 : 64'd17);
    chk("model_lat_3", 64'(ref_lat(32'd3, 0)), EARLY ? 64'd2 : 64'd17);
    run(32'd3, 32'd5, 0, 0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    run(32'h80000000, 32'h80000000, 1, 0);
    run(32'hFFFFFFFD, 32'd7, 1, 5);
    run(32'h12345678, 32'h9ABCDEF0, 0, 0);
    run(32'd5, 32'd0, 0, 0);
    run(32'd5, 32'd3, 0, 0);
    run(32'hDEADBEEF, 32'h7FFFFFFF, 1, 0);
    // abort mid-operation: no result may appear for it
    @(negedge clk);
    bus.in_valid = 1;
    bus.src_a = 32'h0BADF00D;
    bus.src_b = 32'h7FFFFFFF;
    bus.sign = 1;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (7) @(negedge clk);
    bus.cancel = 1;
    @(negedge clk);
    bus.cancel = 0;
    chk("cancel_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("cancel_in_ready", {63'b0, bus.in_ready}, 64'd1);
    run(32'd2, 32'hFFFFFFFC, 1, 0);
    // request together with cancel in IDLE is not taken
    @(negedge clk);
    bus.in_valid = 1;
    bus.cancel = 1;
    bus.src_a = 32'd9;
    bus.src_b = 32'd9;
    @(negedge clk);
    bus.in_valid = 0;
    bus.cancel = 0;
    chk("cancel_idle_in_ready", {63'b0, bus.in_ready}, 64'd1);
    repeat (20) @(negedge clk);
    chk("cancel_idle_no_valid", {63'b0, bus.out_valid}, 64'd0);
    // reset mid-BUSY
    @(negedge clk);
    bus.in_valid = 1;
    bus.src_a = 32'd77;
    bus.src_b = 32'h7FFFFFFF;
    bus.sign = 0;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (5) @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    #1;
    chk("rst_busy_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_busy_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("rst_busy_result", {bus.result_hi, bus.result_lo}, 64'd0);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 3) == 0 ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ~rb;
      run(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
